// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers.
// sbox is also used by the key-expansion stage.
package aes_pkg;

  localparam int Nb         = 4;
  localparam int WORD_SIZE  = 32;
  localparam int BYTE_SIZE  = 8;
  localparam int BLOCK_SIZE = 128;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = b;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round.
// final_i skips MixColumns for the last round.
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_SIZE-1:0] state_i,
  input  logic [BLOCK_SIZE-1:0] rk_i,
  input  logic                  final_i,
  output logic [BLOCK_SIZE-1:0] next_o
);

  localparam int NBYTES = BLOCK_SIZE / BYTE_SIZE;
  localparam int ROWS   = WORD_SIZE / BYTE_SIZE;

  logic [7:0] sb [NBYTES];
  logic [7:0] sr [NBYTES];
  logic [7:0] mc [NBYTES];

  always_comb begin
    for (int i = 0; i < NBYTES; i++)
      sb[i] = sbox(state_i[BLOCK_SIZE-1-BYTE_SIZE*i -: BYTE_SIZE]);
  end

  // Byte i is row i%4, column i/4; row r rotates left by r.
  always_comb begin
    for (int c = 0; c < Nb; c++)
      for (int r = 0; r < ROWS; r++)
        sr[ROWS*c+r] = sb[ROWS*((c+r)%Nb)+r];
  end

  always_comb begin
    for (int c = 0; c < Nb; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    next_o = '0;
    for (int i = 0; i < NBYTES; i++)
      next_o[BLOCK_SIZE-1-BYTE_SIZE*i -: BYTE_SIZE] =
        (final_i ? sr[i] : mc[i])
        ^ rk_i[BLOCK_SIZE-1-BYTE_SIZE*i -: BYTE_SIZE];
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption, one round per clock, valid/ready in and out.
// Define AES_RK_LATCH_EN to capture round_keys on the accepting edge.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BLOCK_SIZE-1:0]         plaintext,
  input  logic [BLOCK_SIZE*(Nr+1)-1:0]  round_keys,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BLOCK_SIZE-1:0]         ciphertext,
  output logic                          busy
);

  localparam int         KW   = BLOCK_SIZE * (Nr + 1);
  localparam logic [3:0] LAST = 4'(Nk + 6);

  aes_state_e            st_q, st_d;
  logic [3:0]            rnd_q, rnd_d;
  logic [BLOCK_SIZE-1:0] blk_q, blk_d;
  logic [BLOCK_SIZE-1:0] ct_q, ct_d;
  logic [BLOCK_SIZE-1:0] rnd_out;
  logic [KW-1:0]         keys;
  logic [BLOCK_SIZE-1:0] rk_a [Nr+1];
  logic                  accept;
  logic                  last;

  assign accept = in_valid & in_ready;
  assign last   = rnd_q == LAST;

`ifdef AES_RK_LATCH_EN
  logic [KW-1:0] keys_q;

  always_ff @(posedge clk) begin
    if (rst)         keys_q <= '0;
    else if (accept) keys_q <= round_keys;
  end

  assign keys = keys_q;
`else
  assign keys = round_keys;
`endif

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk_a[r] = keys[KW-1-BLOCK_SIZE*r -: BLOCK_SIZE];
  end

  aes_round u_round (
    .state_i (blk_q),
    .rk_i    (rk_a[rnd_q]),
    .final_i (last),
    .next_o  (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (in_valid) st_d = ROUND;
      ROUND:   if (last) st_d = DONE;
      DONE:    if (out_ready) st_d = in_valid ? ROUND : IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (st_q)
      IDLE:  in_ready = 1'b1;
      ROUND: busy = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Round 0 key is applied on acceptance from the live bus.
  always_comb begin
    blk_d = blk_q;
    rnd_d = rnd_q;
    ct_d  = ct_q;
    if (accept) begin
      blk_d = plaintext ^ round_keys[KW-1 -: BLOCK_SIZE];
      rnd_d = 4'd1;
    end else if (st_q == ROUND) begin
      blk_d = rnd_out;
      rnd_d = last ? 4'd0 : rnd_q + 4'd1;
      if (last) ct_d = rnd_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
      rnd_q <= '0;
      ct_q  <= '0;
    end else begin
      blk_q <= blk_d;
      rnd_q <= rnd_d;
      ct_q  <= ct_d;
    end
  end

  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter at AES-128/192/256 against a byte-level
// reference model plus known-answer vectors.
module tb_aes_cipher_iter;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    iv, ir, ov, bz;
  logic          ordy;
  logic [127:0]  pt;
  logic [127:0]  ctw [3];
  logic [1407:0] rk0;
  logic [1663:0] rk1;
  logic [1919:0] rk2;
  logic [7:0]    sbt [256];
  int            errors = 0;
  int            checks = 0;

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [191:0] K192 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_cipher_iter #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .plaintext(pt), .round_keys(rk0), .out_valid(ov[0]),
    .out_ready(ordy), .ciphertext(ctw[0]), .busy(bz[0])
  );

  aes_cipher_iter #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .plaintext(pt), .round_keys(rk1), .out_valid(ov[1]),
    .out_ready(ordy), .ciphertext(ctw[1]), .busy(bz[1])
  );

  aes_cipher_iter #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .plaintext(pt), .round_keys(rk2), .out_valid(ov[2]),
    .out_ready(ordy), .ciphertext(ctw[2]), .busy(bz[2])
  );

  // S-box table from the generator-3 walk of GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbt[p] = x ^ 8'h63;
    end
    sbt[0] = 8'h63;
  endtask

  // Carry-less multiply then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // Full schedule, left-aligned in 1920 bits, round 0 at the top.
  function automatic logic [1919:0] kexp(input logic [255:0] key,
                                         input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] o;
    int            tot;
    tot = 4 * (nk + 7);
    rc  = 8'h01;
    o   = '0;
    for (int i = 0; i < tot; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      o[1919-32*i -: 32] = w[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] p,
                                           input logic [1919:0] rks,
                                           input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   acc;
    logic [7:0]   coef;
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      s[i] = p[127-8*i -: 8] ^ rks[1919-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++)
        t[i] = sbt[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          if (r < nr) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
              coef = ((k - row + 4) % 4 == 0) ? 8'h02 :
                     ((k - row + 4) % 4 == 1) ? 8'h03 : 8'h01;
              acc = acc ^ gm(coef, t[4*c+k]);
            end
            s[4*c+row] = acc;
          end else begin
            s[4*c+row] = t[4*c+row];
          end
        end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ rks[1919-128*r-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int sel, input logic [255:0] key);
    logic [1919:0] f;
    f = kexp(key, 4 + 2 * sel);
    case (sel)
      0:       rk0 = f[1919 -: 1408];
      1:       rk1 = f[1919 -: 1664];
      default: rk2 = f;
    endcase
  endtask

  task automatic wait_ov(input int sel, inout int lat);
    while (ov[sel] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic enc(input int sel, input logic [127:0] p,
                     output logic [127:0] c, output int lat);
    pt      = p;
    iv[sel] = 1'b1;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
    lat     = 0;
    wait_ov(sel, lat);
    c = ctw[sel];
  endtask

  task automatic retire();
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
  endtask

  initial begin
    logic [127:0]  c, p, pb, e;
    logic [255:0]  k;
    logic [1919:0] f1, f2, mix;
    int            lat, sel;

    build_sbox();
    rst  = 1'b1;
    iv   = '0;
    ordy = 1'b0;
    pt   = '0;
    rk0  = '0;
    rk1  = '0;
    rk2  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(ir[0]), 128'(1'b1));
    chk("rst_out_valid", 128'(ov[0]), 128'(1'b0));
    chk("rst_busy", 128'(bz[0]), 128'(1'b0));
    chk("rst_ct", ctw[0], 128'h0);
    rst = 1'b0;

    // AES-128 known answers
    set_key(0, {K1, 128'h0});
    enc(0, PT1, c, lat);
    chk("kat128a_ct", c, CT1);
    chk("kat128a_lat", 128'(lat), 128'(10));
    chk("done_in_ready", 128'(ir[0]), 128'(1'b0));
    chk("done_busy", 128'(bz[0]), 128'(1'b0));
    retire();
    chk("retired_ov", 128'(ov[0]), 128'(1'b0));
    chk("retired_ir", 128'(ir[0]), 128'(1'b1));

    set_key(0, {K2, 128'h0});
    enc(0, PT2, c, lat);
    chk("kat128b_ct", c, CT2);
    pt    = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    iv[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      chk("hold_ct", ctw[0], CT2);
      chk("hold_ov", 128'(ov[0]), 128'(1'b1));
      chk("hold_ir", 128'(ir[0]), 128'(1'b0));
    end
    iv[0] = 1'b0;
    retire();

    // AES-192 and AES-256 known answers
    set_key(1, {K192, 64'h0});
    enc(1, PT1, c, lat);
    chk("kat192_ct", c, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("kat192_lat", 128'(lat), 128'(12));
    set_key(2, K256);
    enc(2, PT1, c, lat);
    chk("kat256_ct", c, 128'h8ea2b7ca516745bfeafc49904b496089);
    chk("kat256_lat", 128'(lat), 128'(14));
    retire();

    // Random keys and blocks on all three key sizes
    for (int n = 0; n < 9; n++) begin
      sel = n % 3;
      k = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      set_key(sel, k);
      enc(sel, p, c, lat);
      f1 = kexp(k, 4 + 2 * sel);
      chk("rand_ct", c, ref_enc(p, f1, 10 + 2 * sel));
      chk("rand_lat", 128'(lat), 128'(10 + 2 * sel));
      retire();
    end

    // Back-to-back: second block taken on the retiring edge
    set_key(0, {K1, 128'h0});
    pb    = {$urandom, $urandom, $urandom, $urandom};
    ordy  = 1'b1;
    pt    = PT1;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    pt  = pb;
    lat = 0;
    wait_ov(0, lat);
    chk("b2b_first_lat", 128'(lat), 128'(10));
    chk("b2b_first_ct", ctw[0], CT1);
    chk("b2b_ready", 128'(ir[0]), 128'(1'b1));
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("b2b_ov_drop", 128'(ov[0]), 128'(1'b0));
    chk("b2b_busy", 128'(bz[0]), 128'(1'b1));
    lat = 0;
    wait_ov(0, lat);
    f1 = kexp({K1, 128'h0}, 4);
    chk("b2b_second_lat", 128'(lat), 128'(10));
    chk("b2b_second_ct", ctw[0], ref_enc(pb, f1, 10));
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("b2b_idle", 128'(ov[0]), 128'(1'b0));

    // Reset during round 5
    set_key(0, {K2, 128'h0});
    pt    = PT2;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 128'(bz[0]), 128'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ov", 128'(ov[0]), 128'(1'b0));
    chk("midrst_ir", 128'(ir[0]), 128'(1'b1));
    chk("midrst_ct", ctw[0], 128'h0);
    chk("midrst_busy", 128'(bz[0]), 128'(1'b0));
    set_key(0, {K1, 128'h0});
    enc(0, PT1, c, lat);
    chk("post_rst_ct", c, CT1);
    chk("post_rst_lat", 128'(lat), 128'(10));
    retire();

    // Key bus changes one cycle after acceptance
    set_key(0, {K1, 128'h0});
    f1    = kexp({K1, 128'h0}, 4);
    f2    = kexp({K2, 128'h0}, 4);
    pt    = PT1;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rk0 = f2[1919 -: 1408];
    lat = 1;
    wait_ov(0, lat);
    chk("keychg_lat", 128'(lat), 128'(10));
`ifdef AES_RK_LATCH_EN
    chk("keychg_latched_ct", ctw[0], CT1);
`else
    mix             = f2;
    mix[1919 -: 256] = f1[1919 -: 256];
    e               = ref_enc(PT1, mix, 10);
    chk("keychg_live_ct", ctw[0], e);
    checks++;
    assert (ctw[0] !== CT1) else begin
      errors++;
      $error("FAIL keychg_hazard: observed %h expected not %h", ctw[0], CT1);
    end
`endif
    retire();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
